// File: rtl/hdmi_pcie_fifo_burst_reader_if.sv
// Stream bundle from the burst reader to the PCIe DMA write engine.
// Carries the valid/ready handshake plus per-burst framing.
interface hdmi_pcie_fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 128,
    parameter int LEN_WIDTH  = 9
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic [LEN_WIDTH-1:0]  burst_len;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        output burst_len,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        input  burst_len,
        output m_ready
    );
endinterface

// File: rtl/hdmi_pcie_fifo_burst_reader.sv
// Drains hdmi_pcie_fifo in BURST_LEN-word bursts onto a framed valid/ready stream.
// Define BURST_READER_STATS_EN to add the stat_bursts/stat_stall counters.
module hdmi_pcie_fifo_burst_reader #(
    parameter int DATA_WIDTH  = 128,
    parameter int LEVEL_WIDTH = 13,
    parameter int BURST_LEN   = 16,
    parameter int LEN_WIDTH   = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_level,
    output logic                   fifo_rd_en,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   busy,
`ifdef BURST_READER_STATS_EN
    output logic [31:0]            stat_bursts,
    output logic [31:0]            stat_stall,
`endif
    hdmi_pcie_fifo_burst_reader_if.master m
);

    typedef enum logic {S_IDLE, S_BURST} state_e;

    state_e                state_q;
    logic [LEN_WIDTH-1:0]  beats_left_q;
    logic [LEN_WIDTH-1:0]  burst_len_q;
    logic [LEN_WIDTH-1:0]  out_cnt_q;
    logic                  flush_q;
    logic                  flush_done_q;
    logic                  rd_en_q;
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] buf_q [4];
    logic [1:0]            wptr_q;
    logic [1:0]            rptr_q;
    logic [2:0]            cnt_q;

    logic [2:0] occ;
    logic       issue;
    logic       valid;
    logic       last;
    logic       pop;
    logic       full_rdy;

    // Occupancy counts reads still in the FIFO pipeline so the skid buffer never overflows.
    assign occ      = cnt_q + {2'b00, rd_en_q} + {2'b00, vld_q};
    assign issue    = (state_q == S_BURST) && (beats_left_q != '0)
                      && !fifo_rd_empty && (occ < 3'd4);
    assign valid    = (cnt_q != 3'd0);
    assign last     = valid && ((out_cnt_q + LEN_WIDTH'(1)) == burst_len_q);
    assign pop      = valid && m.m_ready;
    assign full_rdy = fifo_rd_level >= LEVEL_WIDTH'(BURST_LEN);

    assign fifo_rd_en  = rd_en_q;
    assign flush_done  = flush_done_q;
    assign busy        = (state_q != S_IDLE) || valid;
    assign m.m_valid   = valid;
    assign m.m_data    = valid ? buf_q[rptr_q] : '0;
    assign m.m_last    = last;
    assign m.burst_len = burst_len_q;

    always_ff @(posedge clk) begin
        if (vld_q) buf_q[wptr_q] <= fifo_rd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beats_left_q <= '0;
            burst_len_q  <= '0;
            out_cnt_q    <= '0;
            flush_q      <= 1'b0;
            flush_done_q <= 1'b0;
            rd_en_q      <= 1'b0;
            vld_q        <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
        end else begin
            rd_en_q      <= issue;
            vld_q        <= rd_en_q;
            flush_done_q <= 1'b0;
            if (flush_req) flush_q <= 1'b1;
            if (vld_q) wptr_q <= wptr_q + 2'd1;
            if (pop) rptr_q <= rptr_q + 2'd1;
            cnt_q <= cnt_q + {2'b00, vld_q} - {2'b00, pop};
            unique case (state_q)
                S_IDLE: begin
                    if (full_rdy) begin
                        state_q      <= S_BURST;
                        beats_left_q <= LEN_WIDTH'(BURST_LEN);
                        burst_len_q  <= LEN_WIDTH'(BURST_LEN);
                        out_cnt_q    <= '0;
                    end else if (flush_q && (fifo_rd_level != '0)) begin
                        state_q      <= S_BURST;
                        beats_left_q <= fifo_rd_level[LEN_WIDTH-1:0];
                        burst_len_q  <= fifo_rd_level[LEN_WIDTH-1:0];
                        out_cnt_q    <= '0;
                    end else if (flush_q && fifo_rd_empty && !valid) begin
                        flush_done_q <= 1'b1;
                        flush_q      <= flush_req;
                    end
                end
                S_BURST: begin
                    if (issue) beats_left_q <= beats_left_q - LEN_WIDTH'(1);
                    if (pop) out_cnt_q <= out_cnt_q + LEN_WIDTH'(1);
                    if (pop && last) begin
                        state_q   <= S_IDLE;
                        out_cnt_q <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef BURST_READER_STATS_EN
    logic [31:0] stat_bursts_q;
    logic [31:0] stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_bursts_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (pop && last) stat_bursts_q <= stat_bursts_q + 32'd1;
            if (valid && !m.m_ready) stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_bursts = stat_bursts_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_hdmi_pcie_fifo_burst_reader.sv
// Bench for hdmi_pcie_fifo_burst_reader: FIFO model, random ready, burst/flush reference model.
// Build with BURST_READER_STATS_EN to also check the stat counters.
module tb_hdmi_pcie_fifo_burst_reader;
    localparam int DW = 128;
    localparam int LW = 13;
    localparam int BL = 16;
    localparam int NW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty;
    logic [LW-1:0] fifo_rd_level;
    logic          fifo_rd_en;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic          busy;
`ifdef BURST_READER_STATS_EN
    logic [31:0]   stat_bursts;
    logic [31:0]   stat_stall;
`endif

    hdmi_pcie_fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(NW)) s ();

    hdmi_pcie_fifo_burst_reader #(
        .DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .BURST_LEN(BL), .LEN_WIDTH(NW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_level(fifo_rd_level),
        .fifo_rd_en(fifo_rd_en),
        .flush_req(flush_req),
        .flush_done(flush_done),
        .busy(busy),
`ifdef BURST_READER_STATS_EN
        .stat_bursts(stat_bursts),
        .stat_stall(stat_stall),
`endif
        .m(s)
    );

    always #5 clk = ~clk;

    // Source FIFO model: words pushed by the tests, popped by fifo_rd_en.
    logic [DW-1:0] src [0:4095];
    int wr_idx = 0;
    int rd_idx = 0;
    int underflow = 0;
    assign fifo_rd_level = LW'(wr_idx - rd_idx);
    assign fifo_rd_empty = (wr_idx == rd_idx);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_idx <= wr_idx;
        else if (fifo_rd_en) begin
            if (wr_idx == rd_idx) underflow <= underflow + 1;
            else begin
                fifo_rd_data <= src[rd_idx];
                rd_idx <= rd_idx + 1;
            end
        end
    end

    int rmode = 0;
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: s.m_ready = 1'b1;
            1: s.m_ready = ~s.m_ready;
            default: s.m_ready = ($urandom_range(3) != 0);
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    int            got_n[$];
    int            beat_cyc[$];
    int            rd_cyc[$];
    int first_vld = -1;
    int outst = 0, max_outst = 0, stab_err = 0, fdone = 0, stalls = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            outst = 0;
            pv = 1'b0;
        end else begin
            if (pv && !pr && (!s.m_valid || s.m_data !== pd || s.m_last !== pl))
                stab_err++;
            if (fifo_rd_en) begin
                outst++;
                rd_cyc.push_back(cyc);
            end
            if (s.m_valid && s.m_ready) begin
                got_d.push_back(s.m_data);
                got_l.push_back(s.m_last);
                got_n.push_back(int'(s.burst_len));
                beat_cyc.push_back(cyc);
                outst--;
            end
            if (s.m_valid && !s.m_ready) stalls++;
            if (s.m_valid && first_vld < 0) first_vld = cyc;
            if (flush_done) fdone++;
            if (outst > max_outst) max_outst = outst;
            pv = s.m_valid;
            pr = s.m_ready;
            pd = s.m_data;
            pl = s.m_last;
        end
    end

    int nvec = 0;
    int nerr = 0;
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    int            exp_n[$];

    task automatic clr();
        got_d.delete(); got_l.delete(); got_n.delete();
        beat_cyc.delete(); rd_cyc.delete();
        first_vld = -1; max_outst = 0; stab_err = 0; fdone = 0; stalls = 0;
    endtask

    task automatic push_words(input int n, output int base);
        base = wr_idx;
        for (int i = 0; i < n; i++) begin
            src[wr_idx] = {$urandom, $urandom, $urandom, $urandom};
            wr_idx = wr_idx + 1;
        end
    endtask

    // Reference: full bursts of BL while enough words, then one trailing burst if flushed.
    task automatic model(input int base, input int n, input bit fl);
        int k;
        int len;
        exp_d.delete(); exp_l.delete(); exp_n.delete();
        k = 0;
        while (k < n) begin
            if (n - k >= BL) len = BL;
            else if (fl) len = n - k;
            else break;
            for (int i = 0; i < len; i++) begin
                exp_d.push_back(src[base + k + i]);
                exp_l.push_back(i == len - 1);
                exp_n.push_back(len);
            end
            k += len;
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (got_d.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nvec++;
        if ({s.m_valid, s.m_last, fifo_rd_en, flush_done, busy} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {s.m_valid, s.m_last, fifo_rd_en, flush_done, busy});
        end
        nvec++;
        if (s.burst_len !== '0 || s.m_data !== '0) begin
            nerr++;
            $display("FAIL reset_data: len %0d data %h want 0", s.burst_len, s.m_data);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_burst();
        int base;
        bit ok;
        rmode = 0;
        clr();
        push_words(16, base);
        model(base, 16, 1'b0);
        wait_beats(16, 200, ok);
        repeat (6) @(negedge clk);
        nvec++;
        if (!ok || got_d.size() != 16) begin
            nerr++;
            $display("FAIL t1_count: got %0d beats want 16", got_d.size());
        end
        foreach (exp_d[i]) begin
            nvec++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_n[i] !== exp_n[i]) begin
                nerr++;
                $display("FAIL t1_beat%0d: got %h/%0b/%0d want %h/%0b/%0d", i,
                         got_d[i], got_l[i], got_n[i], exp_d[i], exp_l[i], exp_n[i]);
            end
        end
        nvec++;
        if (rd_cyc.size() != 16 || rd_cyc[15] - rd_cyc[0] != 15) begin
            nerr++;
            $display("FAIL t1_rd_b2b: got %0d reads span %0d want 16 span 15",
                     rd_cyc.size(), rd_cyc[rd_cyc.size()-1] - rd_cyc[0]);
        end
        nvec++;
        if (beat_cyc[15] - beat_cyc[0] != 15) begin
            nerr++;
            $display("FAIL t1_beat_b2b: got span %0d want 15", beat_cyc[15] - beat_cyc[0]);
        end
        nvec++;
        if (first_vld - rd_cyc[0] != 2) begin
            nerr++;
            $display("FAIL t1_latency: got %0d want 2", first_vld - rd_cyc[0]);
        end
    endtask

    task automatic test_two_bursts();
        int base;
        bit ok;
        rmode = 0;
        clr();
        push_words(40, base);
        wait_beats(32, 400, ok);
        repeat (10) @(negedge clk);
        nvec++;
        if (!ok || got_d.size() != 32 || s.m_valid !== 1'b0 || busy !== 1'b0 || fifo_rd_level != 8) begin
            nerr++;
            $display("FAIL t2_idle: got beats %0d valid %b busy %b level %0d want 32 0 0 8",
                     got_d.size(), s.m_valid, busy, fifo_rd_level);
        end
        pulse_flush();
        model(base, 40, 1'b1);
        wait_beats(40, 200, ok);
        repeat (8) @(negedge clk);
        nvec++;
        if (!ok || got_d.size() != 40 || fdone != 1) begin
            nerr++;
            $display("FAIL t2_flush: got beats %0d done %0d want 40 1", got_d.size(), fdone);
        end
        foreach (exp_d[i]) begin
            nvec++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_n[i] !== exp_n[i]) begin
                nerr++;
                $display("FAIL t2_beat%0d: got %h/%0b/%0d want %h/%0b/%0d", i,
                         got_d[i], got_l[i], got_n[i], exp_d[i], exp_l[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_flush_partial();
        int base;
        bit ok;
        rmode = 0;
        clr();
        push_words(5, base);
        repeat (6) @(negedge clk);
        nvec++;
        if (got_d.size() != 0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL t3_hold: got beats %0d busy %b want 0 0", got_d.size(), busy);
        end
        pulse_flush();
        model(base, 5, 1'b1);
        wait_beats(5, 100, ok);
        repeat (8) @(negedge clk);
        nvec++;
        if (!ok || got_d.size() != 5 || fdone != 1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL t3_flush: got beats %0d done %0d busy %b want 5 1 0",
                     got_d.size(), fdone, busy);
        end
        foreach (exp_d[i]) begin
            nvec++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_n[i] !== exp_n[i]) begin
                nerr++;
                $display("FAIL t3_beat%0d: got %h/%0b/%0d want %h/%0b/%0d", i,
                         got_d[i], got_l[i], got_n[i], exp_d[i], exp_l[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_ready_toggle();
        int base;
        bit ok;
`ifdef BURST_READER_STATS_EN
        int sb0;
        int ss0;
        sb0 = int'(stat_bursts);
        ss0 = int'(stat_stall);
`endif
        rmode = 1;
        clr();
        push_words(16, base);
        model(base, 16, 1'b0);
        wait_beats(16, 300, ok);
        rmode = 0;
        repeat (6) @(negedge clk);
        nvec++;
        if (!ok || got_d.size() != 16 || max_outst > 4 || stab_err != 0 || underflow != 0) begin
            nerr++;
            $display("FAIL t4_flow: got beats %0d outst %0d unstable %0d underflow %0d want 16 <=4 0 0",
                     got_d.size(), max_outst, stab_err, underflow);
        end
        foreach (exp_d[i]) begin
            nvec++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_n[i] !== exp_n[i]) begin
                nerr++;
                $display("FAIL t4_beat%0d: got %h/%0b/%0d want %h/%0b/%0d", i,
                         got_d[i], got_l[i], got_n[i], exp_d[i], exp_l[i], exp_n[i]);
            end
        end
`ifdef BURST_READER_STATS_EN
        nvec++;
        if (int'(stat_bursts) - sb0 != 1 || int'(stat_stall) - ss0 != stalls) begin
            nerr++;
            $display("FAIL t4_stats: got bursts %0d stalls %0d want 1 %0d",
                     int'(stat_bursts) - sb0, int'(stat_stall) - ss0, stalls);
        end
`endif
    endtask

    task automatic test_flush_repeat();
        int base;
        bit ok;
        rmode = 0;
        clr();
        push_words(19, base);
        model(base, 19, 1'b1);
        wait_beats(3, 100, ok);
        repeat (3) pulse_flush();
        wait_beats(19, 200, ok);
        repeat (8) @(negedge clk);
        nvec++;
        if (!ok || got_d.size() != 19 || fdone != 1) begin
            nerr++;
            $display("FAIL t5_flush: got beats %0d done %0d want 19 1", got_d.size(), fdone);
        end
        foreach (exp_d[i]) begin
            nvec++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_n[i] !== exp_n[i]) begin
                nerr++;
                $display("FAIL t5_beat%0d: got %h/%0b/%0d want %h/%0b/%0d", i,
                         got_d[i], got_l[i], got_n[i], exp_d[i], exp_l[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok;
        rmode = 0;
        clr();
        push_words(16, base);
        wait_beats(6, 100, ok);
        rst_n = 1'b0;
        #1;
        nvec++;
        if (!ok || {s.m_valid, s.m_last, fifo_rd_en, flush_done, busy} !== 5'b0
            || s.burst_len !== '0 || s.m_data !== '0) begin
            nerr++;
            $display("FAIL t6_abort: got ctl %b len %0d data %h want 0",
                     {s.m_valid, s.m_last, fifo_rd_en, flush_done, busy}, s.burst_len, s.m_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clr();
        push_words(16, base);
        model(base, 16, 1'b0);
        wait_beats(16, 200, ok);
        repeat (6) @(negedge clk);
        nvec++;
        if (!ok || got_d.size() != 16) begin
            nerr++;
            $display("FAIL t6_count: got %0d beats want 16", got_d.size());
        end
        foreach (exp_d[i]) begin
            nvec++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_n[i] !== exp_n[i]) begin
                nerr++;
                $display("FAIL t6_beat%0d: got %h/%0b/%0d want %h/%0b/%0d", i,
                         got_d[i], got_l[i], got_n[i], exp_d[i], exp_l[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_random();
        int base;
        int n;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            rmode = 2;
            clr();
            n = $urandom_range(1, 50);
            push_words(n, base);
            model(base, n, 1'b1);
            pulse_flush();
            wait_beats(n, 20 * n + 100, ok);
            rmode = 0;
            repeat (10) @(negedge clk);
            nvec++;
            if (!ok || got_d.size() != n || fdone != 1 || busy !== 1'b0
                || stab_err != 0 || max_outst > 4 || underflow != 0) begin
                nerr++;
                $display("FAIL rnd%0d_flow: n %0d beats %0d done %0d busy %b unstable %0d outst %0d",
                         it, n, got_d.size(), fdone, busy, stab_err, max_outst);
            end
            foreach (exp_d[i]) begin
                nvec++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_n[i] !== exp_n[i]) begin
                    nerr++;
                    $display("FAIL rnd%0d_beat%0d: got %h/%0b/%0d want %h/%0b/%0d", it, i,
                             got_d[i], got_l[i], got_n[i], exp_d[i], exp_l[i], exp_n[i]);
                end
            end
        end
    endtask

    initial begin
        s.m_ready = 1'b0;
        test_reset();
        test_single_burst();
        test_two_bursts();
        test_flush_partial();
        test_ready_toggle();
        test_flush_repeat();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
